// File: rtl/prog_sequencer.sv
// prog_sequencer: start/done run controller. It accepts a start edge and a
// program select, clears the register file and loads the entry PC. It then
// enables the core until halt or the cycle budget runs out, and holds done
// until the next accepted start.
module prog_sequencer #(
  parameter int unsigned PC_W    = 10,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned START0  = 0,
  parameter int unsigned START1  = 128,
  parameter int unsigned START2  = 320,
  parameter int unsigned TIMEOUT = 16'hFFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       prog_sel,
  input  logic             halt_in,
  output logic             rf_clr,
  output logic             pc_load,
  output logic [PC_W-1:0]  pc_start,
  output logic             core_en,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             sel_err,
  output logic [CNT_W-1:0] cycles
);

  // Elaboration-time sanity check on the cycle budget
  if (TIMEOUT < 1 || TIMEOUT >= (64'd1 << CNT_W)) begin : g_bad_timeout
    $error("prog_sequencer: TIMEOUT out of range");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  logic             start_q;
  logic [1:0]       sel;
  logic             start_edge;
  logic [CNT_W-1:0] cycles_inc;
  logic             budget_hit;

  assign start_edge = start & ~start_q;
  assign cycles_inc = cycles + CNT_W'(1);
  assign budget_hit = (cycles_inc == CNT_W'(TIMEOUT));

  // One-cycle strobes and the run enable come straight from the state register
  assign rf_clr  = (state == CLEAR);
  assign pc_load = (state == LOAD);
  assign core_en = (state == RUN);

  // Entry address of the latched program; select 3 never gets latched
  always_comb begin
    pc_start = PC_W'(START0);
    case (sel)
      2'd1:    pc_start = PC_W'(START1);
      2'd2:    pc_start = PC_W'(START2);
      default: pc_start = PC_W'(START0);
    endcase
  end

  // Sequencer state machine with registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      start_q <= 1'b0;
      sel     <= 2'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      sel_err <= 1'b0;
      cycles  <= '0;
    end else begin
      start_q <= start;
      case (state)
        IDLE, DONE: begin
          if (start_edge) begin
            if (prog_sel == 2'd3) begin
              // Rejected request: remain where we are, done untouched
              sel_err <= 1'b1;
            end else begin
              sel     <= prog_sel;
              cycles  <= '0;
              done    <= 1'b0;
              timeout <= 1'b0;
              sel_err <= 1'b0;
              busy    <= 1'b1;
              state   <= CLEAR;
            end
          end
        end
        CLEAR: state <= LOAD;
        LOAD:  state <= RUN;
        RUN: begin
          // The halt cycle itself is counted; halt beats budget exhaustion
          cycles <= cycles_inc;
          if (halt_in) begin
            state   <= DONE;
            done    <= 1'b1;
            timeout <= 1'b0;
            busy    <= 1'b0;
          end else if (budget_hit) begin
            state   <= DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
            busy    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
